// File: rtl/garduino_pio_pkg.sv
// Shared constants for the garduino PIO input/interrupt port: register map and CFG layout.
package garduino_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CFG  = 2'd3;

  localparam int unsigned CFG_W        = 2;
  localparam int unsigned CFG_RISE_BIT = 0;
  localparam int unsigned CFG_FALL_BIT = 1;
  localparam logic [CFG_W-1:0] CFG_RESET = 2'b01;

  // Debounce counter holds 0..14, enough for DEBOUNCE_TICKS up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/garduino_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a tick-driven debounce counter.
module garduino_debounce_bit
  import garduino_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic in_bit,
  output logic deb
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_TICKS == 0) begin : g_bypass
      logic unused_tick;
      assign unused_tick = tick;
      assign deb         = sync2;
    end else begin : g_debounce
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
      logic [CNT_W-1:0] cnt;
      logic             deb_q;

      // Accept a new level only after it disagrees with deb on DEBOUNCE_TICKS consecutive ticks.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          deb_q <= 1'b0;
        end else if (tick) begin
          if (sync2 == deb_q) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            deb_q <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end

      assign deb = deb_q;
    end
  endgenerate

endmodule

// File: rtl/garduino_pio_in_irq.sv
// Avalon-MM input port: debounced DATA, IRQ MASK, W1C EDGE capture and edge-select CFG.
module garduino_pio_in_irq
  import garduino_pio_pkg::*;
#(
  parameter int unsigned WIDTH          = 18,
  parameter int unsigned DEBOUNCE_DIV   = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             tick_c;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_prev;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [CFG_W-1:0] cfg_q;
  logic             wr_c;
  logic [WIDTH-1:0] clr_c;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;
  logic [WIDTH-1:0] edge_next_c;
  logic [31:0]      rd_mux_c;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  // Shared debounce sample tick.
  generate
    if (DEBOUNCE_DIV <= 1) begin : g_no_prescale
      assign tick_c = 1'b1;
    end else begin : g_prescale
      localparam int unsigned PRE_W = $clog2(DEBOUNCE_DIV);
      localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DEBOUNCE_DIV - 1);
      logic [PRE_W-1:0] pre_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pre_cnt <= '0;
        end else if (tick_c) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end

      assign tick_c = (pre_cnt == PRE_LAST);
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    garduino_debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick_c),
      .in_bit (in_port[i]),
      .deb    (deb[i])
    );
  end

  assign wr_c   = chipselect & ~write_n;
  assign clr_c  = (wr_c && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign rise_c = deb & ~deb_prev & {WIDTH{cfg_q[CFG_RISE_BIT]}};
  assign fall_c = ~deb & deb_prev & {WIDTH{cfg_q[CFG_FALL_BIT]}};
  // New edges are OR-ed in after the clear so a coincident W1C never drops an event.
  assign edge_next_c = (edge_q & ~clr_c) | rise_c | fall_c;

  always_comb begin
    rd_mux_c = '0;
    case (address)
      ADDR_DATA: rd_mux_c = 32'(deb);
      ADDR_MASK: rd_mux_c = 32'(mask_q);
      ADDR_EDGE: rd_mux_c = 32'(edge_q);
      ADDR_CFG:  rd_mux_c = 32'(cfg_q);
      default:   rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      cfg_q    <= CFG_RESET;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      deb_prev <= deb;
      edge_q   <= edge_next_c;
      irq      <= |(edge_q & mask_q);
      readdata <= rd_mux_c;
      if (wr_c && (address == ADDR_MASK)) begin
        mask_q <= writedata[WIDTH-1:0];
      end
      if (wr_c && (address == ADDR_CFG)) begin
        cfg_q <= writedata[CFG_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_garduino_pio_in_irq.sv
// Bench for garduino_pio_in_irq: a debounced 18-bit instance and a 32-bit bypass instance on one bus.
module tb_garduino_pio_in_irq;

  localparam int unsigned W  = 18;
  localparam int unsigned WB = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [WB-1:0] in_port_b = '0;
  logic [31:0]   readdata;
  logic [31:0]   readdata_b;
  logic          irq;
  logic          irq_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  garduino_pio_in_irq #(.WIDTH(W), .DEBOUNCE_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  garduino_pio_in_irq #(.WIDTH(WB), .DEBOUNCE_DIV(4), .DEBOUNCE_TICKS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] rd, output logic [31:0] rdb);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    rd = readdata; rdb = readdata_b;
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, rdb;
    logic [31:0] exp_regs [4];
    exp_regs[0] = 32'h0; exp_regs[1] = 32'h0; exp_regs[2] = 32'h0; exp_regs[3] = 32'h1;
    in_port = '0; in_port_b = '0;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd, rdb);
      checks++;
      if (rd !== exp_regs[a]) begin
        failures++; $display("FAIL reset_reg%0d got=%08h exp=%08h", a, rd, exp_regs[a]);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
  endtask

  task automatic test_debounce_accept();
    logic [31:0] rd, rdb;
    int n;
    bit seen;
    seen = 1'b0; n = 0;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    in_port[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (!seen && readdata[0] === 1'b1) begin
        seen = 1'b1; n = c;
      end
    end
    chipselect = 1'b0;
    checks++;
    if (!seen || n < 12 || n > 15) begin
      failures++; $display("FAIL accept_latency got_seen=%0d got_cycles=%0d exp_cycles=12..15", seen, n);
    end
    repeat (4) @(negedge clk);
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("FAIL accept_edge got=%08h exp=00000001", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL accept_irq_masked got=%b exp=0", irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] rd, rdb;
    @(negedge clk);
    in_port[3] = 1'b1;
    repeat (6) @(negedge clk);
    in_port[3] = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(2'd0, rd, rdb);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("FAIL glitch_data got=%08h exp=00000001", rd);
    end
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("FAIL glitch_edge got=%08h exp=00000001", rd);
    end
  endtask

  task automatic test_irq_w1c();
    logic [31:0] rd, rdb;
    bus_write(2'd1, 32'h1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_set got=%b exp=1", irq);
    end
    bus_write(2'd2, 32'h1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_w1c_drop got=%b exp=0", irq);
    end
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL w1c_edge got=%08h exp=00000000", rd);
    end
  endtask

  task automatic test_fall_collision();
    logic [31:0] rd, rdb;
    bus_write(2'd3, 32'h2);
    @(negedge clk); in_port[5] = 1'b1;
    repeat (20) @(negedge clk);
    in_port[5] = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rd !== 32'h20) begin
      failures++; $display("FAIL fall_capture got=%08h exp=00000020", rd);
    end
    in_port[5] = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rd !== 32'h20) begin
      failures++; $display("FAIL fall_only_no_rise got=%08h exp=00000020", rd);
    end
    bus_write(2'd2, 32'h20);
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL fall_clear got=%08h exp=00000000", rd);
    end
    // Bypass instance gives a cycle-exact falling edge to collide with.
    @(negedge clk); in_port_b[5] = 1'b1;
    repeat (5) @(negedge clk);
    in_port_b[5] = 1'b0;
    @(negedge clk);
    bus_write(2'd2, 32'h20);
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rdb !== 32'h20) begin
      failures++; $display("FAIL collision_set_wins got=%08h exp=00000020", rdb);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] rd, rdb;
    in_port_b = '0;
    bus_write(2'd3, 32'h1);
    repeat (4) @(negedge clk);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    checks++;
    if (irq_b !== 1'b0) begin
      failures++; $display("FAIL bypass_irq_idle got=%b exp=0", irq_b);
    end
    chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    in_port_b = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (readdata_b !== 32'h0) begin
      failures++; $display("FAIL bypass_data_k1 got=%08h exp=00000000", readdata_b);
    end
    @(negedge clk);
    checks++;
    if (readdata_b !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL bypass_data_k2 got=%08h exp=ffffffff", readdata_b);
    end
    checks++;
    if (irq_b !== 1'b0) begin
      failures++; $display("FAIL bypass_irq_k2 got=%b exp=0", irq_b);
    end
    @(negedge clk);
    checks++;
    if (irq_b !== 1'b1) begin
      failures++; $display("FAIL bypass_irq_k3 got=%b exp=1", irq_b);
    end
    chipselect = 1'b0;
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rdb !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL bypass_edge got=%08h exp=ffffffff", rdb);
    end
  endtask

  // Settled-level model: each held input value becomes DATA; level changes are edges filtered by CFG.
  task automatic test_random();
    logic [31:0] rd, rdb, wd;
    logic [W-1:0] m_deb, m_edge, m_mask, nv, gm;
    logic [1:0]   m_cfg;
    logic         m_irq;
    int op, len;
    in_port = '0; in_port_b = '0;
    do_reset();
    m_deb = '0; m_edge = '0; m_mask = '0; m_cfg = 2'b01;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0, 1: begin
          nv = W'($urandom);
          @(negedge clk); in_port = nv;
          repeat (20) @(negedge clk);
          if (m_cfg[0]) m_edge = m_edge | (nv & ~m_deb);
          if (m_cfg[1]) m_edge = m_edge | (~nv & m_deb);
          m_deb = nv;
        end
        2: begin
          gm  = W'($urandom);
          len = int'($urandom_range(1, 7));
          @(negedge clk); in_port = m_deb ^ gm;
          repeat (len) @(negedge clk);
          in_port = m_deb;
          repeat (10) @(negedge clk);
        end
        3: begin
          wd = $urandom;
          bus_write(2'd1, wd);
          m_mask = wd[W-1:0];
        end
        default: begin
          wd = $urandom;
          if ($urandom_range(0, 1) == 0) begin
            bus_write(2'd3, wd);
            m_cfg = wd[1:0];
          end else begin
            bus_write(2'd2, wd);
            m_edge = m_edge & ~wd[W-1:0];
          end
        end
      endcase
      bus_read(2'd0, rd, rdb);
      checks++;
      if (rd !== 32'(m_deb)) begin
        failures++; $display("FAIL rand_data it=%0d got=%08h exp=%08h", it, rd, 32'(m_deb));
      end
      bus_read(2'd2, rd, rdb);
      checks++;
      if (rd !== 32'(m_edge)) begin
        failures++; $display("FAIL rand_edge it=%0d got=%08h exp=%08h", it, rd, 32'(m_edge));
      end
      bus_read(2'd3, rd, rdb);
      checks++;
      if (rd !== 32'(m_cfg)) begin
        failures++; $display("FAIL rand_cfg it=%0d got=%08h exp=%08h", it, rd, 32'(m_cfg));
      end
      m_irq = |(m_edge & m_mask);
      checks++;
      if (irq !== m_irq) begin
        failures++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq, m_irq);
      end
    end
    // Asynchronous reset mid-debounce, then an input held high through reset.
    bus_write(2'd1, 32'hFFFF_FFFF);
    nv = W'($urandom) | W'(1);
    @(negedge clk); in_port = nv;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      failures++; $display("FAIL async_reset got_rd=%08h got_irq=%b exp=0/0", readdata, irq);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(2'd0, rd, rdb);
    checks++;
    if (rd !== 32'(nv)) begin
      failures++; $display("FAIL held_data got=%08h exp=%08h", rd, 32'(nv));
    end
    bus_read(2'd2, rd, rdb);
    checks++;
    if (rd !== 32'(nv)) begin
      failures++; $display("FAIL held_edge got=%08h exp=%08h", rd, 32'(nv));
    end
  endtask

  initial begin
    test_reset();
    test_debounce_accept();
    test_glitch();
    test_irq_w1c();
    test_fall_collision();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
